audio_dac_tx: RTL
=================

AUDIO_DAC_TX -- requirements
Module: audio_dac_tx

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16: bits per channel; FIFO word is 2*SAMPLE_W bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for codec clock inputs.
REQ-003 CLK  input  1  system clock (50 MHz); sole clock of the block.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 AUD_BCLK  input  1  codec bit clock (codec is master); asynchronous to CLK.
REQ-006 AUD_DAC_LRCK  input  1  codec left/right clock; low = left, high = right.
REQ-007 AUD_DAC_DATA  output  1  serial DAC data, I2S format, MSB first.
REQ-008 q  input  2*SAMPLE_W  FIFO show-ahead data, {left, right}; left in the upper half.
REQ-009 rdempty  input  1  FIFO empty flag, CLK domain.
REQ-010 rdreq  output  1  FIFO read acknowledge; one-CLK pulse per consumed word.
REQ-011 underrun_cnt  output  16  count of frames sent while the FIFO was empty.
REQ-012 active  output  1  high once the first left frame start is seen after reset.

Function
REQ-013 AUD_BCLK and AUD_DAC_LRCK SHALL each pass through SYNC_STAGES flops and then an edge register; both paths SHALL have equal latency.
REQ-014 bclk_fall SHALL be a one-CLK pulse on a synchronized 1->0 transition of AUD_BCLK; lr_fall and lr_rise likewise for AUD_DAC_LRCK.
REQ-015 FSM states SHALL be WAIT_SYNC, LEFT and RIGHT; reset state is WAIT_SYNC.
REQ-016 WAIT_SYNC -> LEFT on lr_fall; LEFT -> RIGHT on lr_rise; RIGHT -> LEFT on lr_fall; no other transitions.
REQ-017 On every lr_fall, in any state: if !rdempty, q SHALL be latched into the frame register and rdreq pulsed in that same cycle.
REQ-018 On lr_fall with rdempty high: frame register SHALL load all zeros, rdreq SHALL stay low, and underrun_cnt SHALL increment.
REQ-019 On lr_fall and lr_rise: bit index SHALL reset to 0 and select the left or right half, with no bit shifted in that cycle (I2S one-BCLK delay slot).
REQ-020 On each later bclk_fall: AUD_DAC_DATA SHALL take bit (SAMPLE_W-1-index) of the current half, then index increments.
REQ-021 After SAMPLE_W bits in a half, AUD_DAC_DATA SHALL drive 0 until the next LRCK edge; the index SHALL saturate and not wrap.
REQ-022 If an LRCK edge and bclk_fall occur in the same cycle, the LRCK edge SHALL take priority.
REQ-023 AUD_DAC_DATA SHALL be registered and SHALL update in the CLK cycle after bclk_fall detection.
REQ-024 In WAIT_SYNC, AUD_DAC_DATA SHALL be 0, rdreq 0 and active 0.
REQ-025 active SHALL be set on the first lr_fall and held high until reset.
REQ-026 rdreq SHALL never assert while rdempty is high, and SHALL assert at most once per LRCK period.
REQ-027 underrun_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-028 reset_n low SHALL asynchronously clear all synchronizers, FSM (WAIT_SYNC), frame register, bit index, AUD_DAC_DATA, rdreq, active and underrun_cnt to 0.
REQ-029 Reset deassertion mid-frame SHALL resume output only at the next lr_fall; no partial frame is emitted.
REQ-030 Reset SHALL NOT cause a FIFO read.

Configuration
REQ-031 With macro AUDIO_DAC_TX_UNDERRUN_CNT_EN defined, the underrun counter SHALL be implemented as specified.
REQ-032 Without AUDIO_DAC_TX_UNDERRUN_CNT_EN, underrun_cnt SHALL be tied to 0 with no counter logic; all other behaviour is identical.

Structure
REQ-033 Package audio_pkg SHALL hold the FSM state enum (WAIT_SYNC, LEFT, RIGHT), default SAMPLE_W and the underrun counter width.
REQ-034 Synchronizer plus edge detect SHALL be a sub-module, audio_sync_edge, instantiated once per codec clock input.

Verification
REQ-035 BCLK = 3.072 MHz, LRCK = 48 kHz, FIFO holds 32'hA5F0_0F5A -> one rdreq pulse at lr_fall; DAC line carries left 16'hA5F0 then right 16'h0F5A, MSB one BCLK after each LRCK edge.
REQ-036 FIFO empty at lr_fall -> 32 zero bits, rdreq low, underrun_cnt 0 -> 1; with macro undefined, underrun_cnt stays 0.
REQ-037 Stimulus begins with LRCK high after reset -> DAC line 0 and active 0 until the first lr_fall; then left data starts.
REQ-038 64 BCLK per frame with SAMPLE_W=16 -> bits 17..32 of each half are 0 and the index does not wrap.
REQ-039 reset_n pulsed low mid-left-word -> outputs 0 immediately; next output is a full frame after the next lr_fall, with no extra rdreq.
REQ-040 Continuous FIFO data over 1000 frames with random CLK/BCLK phase -> exactly 1000 rdreq pulses and bit-exact serial data.

Source files
------------

// File: rtl/audio_dac_tx_pkg.sv
// audio_pkg: shared types and constants for the audio DAC transmitter slice.
//   state_t      - framing FSM states (WAIT_SYNC, LEFT, RIGHT)
//   SAMPLE_W_DEF - default bits per channel
//   UNDERRUN_W   - width of the underrun frame counter
`timescale 1ns/1ps
package audio_pkg;
  localparam int unsigned SAMPLE_W_DEF = 16;
  localparam int unsigned UNDERRUN_W   = 16;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    LEFT      = 2'd1,
    RIGHT     = 2'd2
  } state_t;
endpackage

// File: rtl/audio_dac_tx_if.sv
// audio_dac_tx_if: show-ahead FIFO read port feeding the DAC transmitter.
//   q       - FIFO head word {left, right}, left in the upper half
//   rdempty - FIFO empty flag (CLK domain)
//   rdreq   - one-cycle read acknowledge per consumed word
// Modports: master = reader (transmitter), slave = FIFO side.
`timescale 1ns/1ps
interface audio_dac_tx_if
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF
);
  logic [2*SAMPLE_W-1:0] q;
  logic                  rdempty;
  logic                  rdreq;

  modport master (input q, input rdempty, output rdreq);
  modport slave  (output q, output rdempty, input rdreq);
endinterface

// File: rtl/audio_sync_edge.sv
// audio_sync_edge: brings one asynchronous codec clock into the CLK domain
// through SYNC_STAGES flops followed by an edge register, and produces
// one-cycle rise/fall pulses. Every instance has identical latency, so
// edges of BCLK and LRCK that coincide at the pins coincide here too.
//   clk, rst_n - system clock, asynchronous active-low reset
//   async_in   - codec clock input
//   rise, fall - one-CLK pulses on synchronized 0->1 / 1->0 transitions
`timescale 1ns/1ps
module audio_sync_edge
  import audio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(async_in);
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & edge_q;
endmodule

// File: rtl/audio_dac_tx.sv
// audio_dac_tx: I2S DAC serializer slaved to codec-mastered BCLK/LRCK.
// Reads one {left,right} word from a show-ahead FIFO at each LRCK falling
// edge and shifts it out MSB first, one BCLK after each LRCK edge.
//   CLK, reset_n   - system clock, asynchronous active-low reset
//   AUD_BCLK       - codec bit clock (async)
//   AUD_DAC_LRCK   - codec LR clock (async), low = left
//   AUD_DAC_DATA   - registered serial data
//   fifo           - FIFO read port (master side)
//   underrun_cnt   - frames sent while FIFO empty (saturating)
//   active         - set at first left frame start after reset
// Optional feature: define AUDIO_DAC_TX_UNDERRUN_CNT_EN to build the
// underrun counter; otherwise underrun_cnt is tied to zero.
`timescale 1ns/1ps
module audio_dac_tx
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_W    = SAMPLE_W_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  reset_n,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_DAC_LRCK,
  output logic                  AUD_DAC_DATA,
  audio_dac_tx_if.master        fifo,
  output logic [UNDERRUN_W-1:0] underrun_cnt,
  output logic                  active
);
  localparam int unsigned      IDX_W   = $clog2(SAMPLE_W + 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(SAMPLE_W);

  logic bclk_fall, bclk_rise_unused, lr_fall, lr_rise;

  audio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
    .clk      (CLK),
    .rst_n    (reset_n),
    .async_in (AUD_BCLK),
    .rise     (bclk_rise_unused),
    .fall     (bclk_fall)
  );

  audio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lrck_sync (
    .clk      (CLK),
    .rst_n    (reset_n),
    .async_in (AUD_DAC_LRCK),
    .rise     (lr_rise),
    .fall     (lr_fall)
  );

  state_t                state_q, state_d;
  logic [2*SAMPLE_W-1:0] frame_q;
  logic                  right_sel_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  data_q;
  logic                  active_q;
  logic [SAMPLE_W-1:0]   half;
  logic                  cur_bit;
  logic                  in_frame;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) state_q <= WAIT_SYNC;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    fifo.rdreq = 1'b0;
    // The FIFO is consumed on every left frame start, whatever the state.
    fifo.rdreq = lr_fall & ~fifo.rdempty;
    unique case (state_q)
      WAIT_SYNC: if (lr_fall) state_d = LEFT;
      LEFT:      if (lr_rise) state_d = RIGHT;
      RIGHT:     if (lr_fall) state_d = LEFT;
      default:   state_d = WAIT_SYNC;
    endcase
  end

  assign in_frame = (state_q != WAIT_SYNC);
  assign half     = right_sel_q ? frame_q[SAMPLE_W-1:0] : frame_q[2*SAMPLE_W-1:SAMPLE_W];

  always_comb begin
    cur_bit = 1'b0;
    for (int unsigned i = 0; i < SAMPLE_W; i++) begin
      if (IDX_W'(i) == idx_q) cur_bit = half[SAMPLE_W-1-i];
    end
  end

  // LRCK edges win over a coincident BCLK fall and shift nothing: that
  // cycle is the I2S one-bit delay slot. The index parks at SAMPLE_W so
  // extra BCLKs in a long slot emit zeros instead of wrapping.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      frame_q     <= '0;
      right_sel_q <= 1'b0;
      idx_q       <= '0;
      data_q      <= 1'b0;
      active_q    <= 1'b0;
    end else if (lr_fall) begin
      frame_q     <= fifo.rdempty ? '0 : fifo.q;
      right_sel_q <= 1'b0;
      idx_q       <= '0;
      active_q    <= 1'b1;
    end else if (lr_rise && in_frame) begin
      right_sel_q <= 1'b1;
      idx_q       <= '0;
    end else if (bclk_fall && in_frame) begin
      if (idx_q != IDX_MAX) begin
        data_q <= cur_bit;
        idx_q  <= idx_q + 1'b1;
      end else begin
        data_q <= 1'b0;
      end
    end
  end

  assign AUD_DAC_DATA = data_q;
  assign active       = active_q;

`ifdef AUDIO_DAC_TX_UNDERRUN_CNT_EN
  logic [UNDERRUN_W-1:0] underrun_q;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      underrun_q <= '0;
    end else if (lr_fall && fifo.rdempty && (underrun_q != '1)) begin
      underrun_q <= underrun_q + 1'b1;
    end
  end

  assign underrun_cnt = underrun_q;
`else
  assign underrun_cnt = '0;
`endif
endmodule
